// File: rtl/lumos_pkg.sv
// Shared encodings for the MEM-stage load/store path: decode codes, access sizes
// and the bridge FSM states.
package lumos_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [2:0] MR_LW   = 3'b000;
    localparam logic [2:0] MR_LB   = 3'b001;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LBU  = 3'b011;
    localparam logic [2:0] MR_LHU  = 3'b100;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    // Store encoding takes precedence; unknown load codes fall back to word size.
    function automatic logic [2:0] access_size(input logic is_store,
                                               input logic [1:0] mem_write,
                                               input logic [2:0] mem_read);
        logic [2:0] size;
        if (is_store) begin
            case (mem_write)
                MW_SB:   size = SIZE_BYTE;
                MW_SH:   size = SIZE_HALF;
                default: size = SIZE_WORD;
            endcase
        end else begin
            case (mem_read)
                MR_LB, MR_LBU: size = SIZE_BYTE;
                MR_LH, MR_LHU: size = SIZE_HALF;
                default:       size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Merges the two read beats, shifts the addressed bytes down to lane 0 and
// applies sign/zero extension for the load type.
module lsu_load_align
    import lumos_pkg::*;
(
    input  logic [31:0] beat1,
    input  logic [31:0] beat2,
    input  logic [1:0]  off,
    input  logic [2:0]  mem_read,
    output logic [31:0] data
);

    logic [63:0] merged_s;
    logic [31:0] raw_s;

    // Shift-and-extend of the 64-bit beat pair.
    always_comb begin
        merged_s = {beat2, beat1} >> {off, 3'b000};
        raw_s    = merged_s[31:0];
        case (mem_read)
            MR_LB:   data = {{24{raw_s[7]}}, raw_s[7:0]};
            MR_LH:   data = {{16{raw_s[15]}}, raw_s[15:0]};
            MR_LBU:  data = {24'h000000, raw_s[7:0]};
            MR_LHU:  data = {16'h0000, raw_s[15:0]};
            default: data = raw_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// MEM-stage load/store unit: turns decoded memory codes into one or two aligned
// valid/ready bus transactions and stalls the pipeline until the access ends.
module lsu_mem_bridge
    import lumos_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  mem_write,
    input  logic        is_load,
    input  logic [2:0]  mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic SPLIT_OK = (ALLOW_MISALIGNED != 32'sd0);

    lsu_state_e  state_r, next_state_s;
    logic        bus_valid_r, bus_we_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_addr_r, bus_wdata_r, beat1_r, load_data_r;

    logic        is_store_s, access_s, cross_s, block_s;
    logic [2:0]  size_s;
    logic [1:0]  off_s;
    logic [7:0]  mask_s;
    logic [63:0] wlane_s;
    logic [31:0] aligned_s, align_b1_s, align_b2_s, align_out_s;

    // Access decode, crossing detection and lane placement.
    always_comb begin
        is_store_s = (mem_write != MW_NONE);
        access_s   = req_valid & (is_load | is_store_s);
        size_s     = access_size(is_store_s, mem_write, mem_read);
        off_s      = addr[1:0];
        cross_s    = (({1'b0, off_s} + size_s) > 3'd4);
        block_s    = access_s & cross_s & ~SPLIT_OK & (state_r == ST_IDLE);
        aligned_s  = {addr[31:2], 2'b00};
        wlane_s    = {32'h0000_0000, wdata} << {off_s, 3'b000};
        case (size_s)
            SIZE_BYTE: mask_s = 8'h01 << off_s;
            SIZE_HALF: mask_s = 8'h03 << off_s;
            default:   mask_s = 8'h0F << off_s;
        endcase
    end

    // The beat arriving this cycle bypasses the capture register into the aligner.
    always_comb begin
        if (state_r == ST_WAIT1) begin
            align_b1_s = bus_rdata;
        end else begin
            align_b1_s = beat1_r;
        end
        if (state_r == ST_WAIT2) begin
            align_b2_s = bus_rdata;
        end else begin
            align_b2_s = 32'h0000_0000;
        end
    end

    lsu_load_align u_align (
        .beat1    (align_b1_s),
        .beat2    (align_b2_s),
        .off      (off_s),
        .mem_read (mem_read),
        .data     (align_out_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s && !block_s) begin
                    next_state_s = ST_REQ1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ1: begin
                if (!bus_ready) begin
                    next_state_s = ST_REQ1;
                end else if (!is_store_s) begin
                    next_state_s = ST_WAIT1;
                end else if (cross_s) begin
                    next_state_s = ST_REQ2;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_WAIT1: begin
                if (!bus_rvalid) begin
                    next_state_s = ST_WAIT1;
                end else if (cross_s) begin
                    next_state_s = ST_REQ2;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_REQ2: begin
                if (!bus_ready) begin
                    next_state_s = ST_REQ2;
                end else if (is_store_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (bus_rvalid) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT2;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, bus request fields and load capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bus_valid_r <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_be_r    <= 4'b0000;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            beat1_r     <= 32'h0000_0000;
            load_data_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == ST_REQ1) begin
                bus_valid_r <= 1'b1;
                bus_we_r    <= is_store_s;
                bus_be_r    <= mask_s[3:0];
                bus_addr_r  <= aligned_s;
                bus_wdata_r <= is_store_s ? wlane_s[31:0] : 32'h0000_0000;
            end else if (next_state_s == ST_REQ2) begin
                bus_valid_r <= 1'b1;
                bus_we_r    <= is_store_s;
                bus_be_r    <= mask_s[7:4];
                bus_addr_r  <= aligned_s + 32'd4;
                bus_wdata_r <= is_store_s ? wlane_s[63:32] : 32'h0000_0000;
            end else begin
                bus_valid_r <= 1'b0;
                bus_we_r    <= 1'b0;
                bus_be_r    <= 4'b0000;
                bus_addr_r  <= 32'h0000_0000;
                bus_wdata_r <= 32'h0000_0000;
            end
            if (state_r == ST_WAIT1 && bus_rvalid) begin
                beat1_r <= bus_rdata;
            end else begin
                beat1_r <= beat1_r;
            end
            if ((state_r == ST_WAIT1 || state_r == ST_WAIT2) && bus_rvalid && next_state_s == ST_DONE) begin
                load_data_r <= align_out_s;
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

    assign stall        = access_s & (state_r != ST_DONE) & ~block_s;
    assign done         = (state_r == ST_DONE) | block_s;
    assign misalign_err = block_s;
    assign bus_valid    = bus_valid_r;
    assign bus_we       = bus_we_r;
    assign bus_be       = bus_be_r;
    assign bus_addr     = bus_addr_r;
    assign bus_wdata    = bus_wdata_r;
    assign load_data    = load_data_r;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: splitting instance plus a no-split instance
// for the misalignment error path.
module tb_lsu_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, is_load, bus_ready, bus_rvalid;
    logic [1:0]  mem_write;
    logic [2:0]  mem_read;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, done, misalign_err, bus_valid, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] load_data, bus_addr, bus_wdata;

    logic        m_req_valid, m_is_load, m_bus_ready, m_bus_rvalid;
    logic [1:0]  m_mem_write;
    logic [2:0]  m_mem_read;
    logic [31:0] m_addr, m_wdata, m_bus_rdata;
    logic        m_stall, m_done, m_misalign_err, m_bus_valid, m_bus_we;
    logic [3:0]  m_bus_be;
    logic [31:0] m_load_data, m_bus_addr, m_bus_wdata;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lsu_mem_bridge #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
        .is_load(is_load), .mem_read(mem_read), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .done(done), .misalign_err(misalign_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    lsu_mem_bridge #(.ALLOW_MISALIGNED(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(m_req_valid), .mem_write(m_mem_write),
        .is_load(m_is_load), .mem_read(m_mem_read), .addr(m_addr), .wdata(m_wdata),
        .stall(m_stall), .load_data(m_load_data), .done(m_done),
        .misalign_err(m_misalign_err), .bus_valid(m_bus_valid), .bus_ready(m_bus_ready),
        .bus_we(m_bus_we), .bus_be(m_bus_be), .bus_addr(m_bus_addr),
        .bus_wdata(m_bus_wdata), .bus_rvalid(m_bus_rvalid), .bus_rdata(m_bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; is_load = 1'b0; mem_write = 2'b00; mem_read = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        idle_req();
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        m_req_valid = 1'b0; m_is_load = 1'b0; m_mem_write = 2'b00; m_mem_read = 3'b000;
        m_addr = 32'h0; m_wdata = 32'h0; m_bus_ready = 1'b1; m_bus_rvalid = 1'b0; m_bus_rdata = 32'h0;

        // Reset values
        cyc(); cyc();
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_stall_idle", {31'h0, stall}, 32'h0);
        req_valid = 1'b1; mem_write = 2'b11; #1;
        chk("rst_stall_follows", {31'h0, stall}, 32'h1);
        idle_req();
        rst = 1'b0;

        // sw 0x100: IDLE, REQ1, DONE
        cyc();
        req_valid = 1'b1; mem_write = 2'b11; addr = 32'h100; wdata = 32'hDEADBEEF; #1;
        chk("sw_c1_stall", {31'h0, stall}, 32'h1);
        chk("sw_c1_valid", {31'h0, bus_valid}, 32'h0);
        cyc();
        chk("sw_c2_valid", {31'h0, bus_valid}, 32'h1);
        chk("sw_c2_we", {31'h0, bus_we}, 32'h1);
        chk("sw_c2_addr", bus_addr, 32'h100);
        chk("sw_c2_be", {28'h0, bus_be}, 32'hF);
        chk("sw_c2_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_c2_stall", {31'h0, stall}, 32'h1);
        cyc();
        chk("sw_c3_done", {31'h0, done}, 32'h1);
        chk("sw_c3_stall", {31'h0, stall}, 32'h0);
        chk("sw_c3_valid", {31'h0, bus_valid}, 32'h0);
        idle_req();
        cyc();
        chk("sw_after_done", {31'h0, done}, 32'h0);

        // sb 0x203
        req_valid = 1'b1; mem_write = 2'b01; addr = 32'h203; wdata = 32'h000000A5;
        cyc();
        chk("sb_addr", bus_addr, 32'h200);
        chk("sb_be", {28'h0, bus_be}, 32'h8);
        chk("sb_wdata", bus_wdata, 32'hA5000000);
        cyc();
        chk("sb_done", {31'h0, done}, 32'h1);
        idle_req();

        // lb 0x301, then lbu with the same data
        for (int k = 0; k < 2; k++) begin
            cyc();
            req_valid = 1'b1; is_load = 1'b1; mem_read = (k == 0) ? 3'b001 : 3'b011; addr = 32'h301;
            cyc();
            chk("lb_req_valid", {31'h0, bus_valid}, 32'h1);
            chk("lb_req_we", {31'h0, bus_we}, 32'h0);
            chk("lb_req_addr", bus_addr, 32'h300);
            chk("lb_req_be", {28'h0, bus_be}, 32'h2);
            cyc();
            chk("lb_wait_stall", {31'h0, stall}, 32'h1);
            chk("lb_wait_valid", {31'h0, bus_valid}, 32'h0);
            bus_rvalid = 1'b1; bus_rdata = 32'h00008000;
            cyc();
            bus_rvalid = 1'b0;
            chk("lb_done", {31'h0, done}, 32'h1);
            chk("lb_stall_low", {31'h0, stall}, 32'h0);
            chk("lb_data", load_data, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
            idle_req();
        end

        // lw 0x402 crossing: reads at 0x400 and 0x404
        cyc();
        req_valid = 1'b1; is_load = 1'b1; mem_read = 3'b000; addr = 32'h402;
        cyc();
        chk("lwx_b1_addr", bus_addr, 32'h400);
        chk("lwx_b1_be", {28'h0, bus_be}, 32'hC);
        chk("lwx_no_err", {31'h0, misalign_err}, 32'h0);
        cyc();
        bus_rvalid = 1'b1; bus_rdata = 32'hBBBBAAAA;
        cyc();
        bus_rvalid = 1'b0;
        chk("lwx_b2_valid", {31'h0, bus_valid}, 32'h1);
        chk("lwx_b2_addr", bus_addr, 32'h404);
        chk("lwx_b2_be", {28'h0, bus_be}, 32'h3);
        chk("lwx_b2_stall", {31'h0, stall}, 32'h1);
        cyc();
        bus_rvalid = 1'b1; bus_rdata = 32'hDDDDCCCC;
        cyc();
        bus_rvalid = 1'b0;
        chk("lwx_done", {31'h0, done}, 32'h1);
        chk("lwx_data", load_data, 32'hCCCCBBBB);
        idle_req();

        // sh 0x503 crossing with ready low for three cycles
        cyc();
        req_valid = 1'b1; mem_write = 2'b10; addr = 32'h503; wdata = 32'h00001234; bus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("shx_b1_valid", {31'h0, bus_valid}, 32'h1);
            chk("shx_b1_addr", bus_addr, 32'h500);
            chk("shx_b1_be", {28'h0, bus_be}, 32'h8);
            chk("shx_b1_wdata", bus_wdata, 32'h34000000);
            chk("shx_b1_stall", {31'h0, stall}, 32'h1);
        end
        bus_ready = 1'b1;
        cyc();
        chk("shx_b2_addr", bus_addr, 32'h504);
        chk("shx_b2_be", {28'h0, bus_be}, 32'h1);
        chk("shx_b2_wdata", bus_wdata, 32'h00000012);
        chk("shx_b2_stall", {31'h0, stall}, 32'h1);
        cyc();
        chk("shx_done", {31'h0, done}, 32'h1);
        idle_req();

        // Reset while a request is pending: bus_valid drops without a clock edge
        cyc();
        req_valid = 1'b1; is_load = 1'b1; mem_read = 3'b000; addr = 32'h700; bus_ready = 1'b0;
        cyc();
        chk("rreq_valid", {31'h0, bus_valid}, 32'h1);
        rst = 1'b1; #1;
        chk("rreq_valid_async", {31'h0, bus_valid}, 32'h0);
        chk("rreq_addr_async", bus_addr, 32'h0);
        idle_req(); bus_ready = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset in WAIT1: no done, late rvalid ignored
        cyc();
        req_valid = 1'b1; is_load = 1'b1; mem_read = 3'b000; addr = 32'h600;
        cyc();
        cyc();
        chk("rw1_stall", {31'h0, stall}, 32'h1);
        rst = 1'b1; #1;
        chk("rw1_valid", {31'h0, bus_valid}, 32'h0);
        chk("rw1_done", {31'h0, done}, 32'h0);
        idle_req();
        cyc();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        cyc();
        bus_rvalid = 1'b0;
        chk("rw1_no_done", {31'h0, done}, 32'h0);
        chk("rw1_load_data", load_data, 32'h0);
        chk("rw1_idle_valid", {31'h0, bus_valid}, 32'h0);

        // No-split instance: crossing lw flags an error, non-crossing lbu does not
        m_req_valid = 1'b1; m_is_load = 1'b1; m_mem_read = 3'b000; m_addr = 32'h402; #1;
        chk("mis_err", {31'h0, m_misalign_err}, 32'h1);
        chk("mis_done", {31'h0, m_done}, 32'h1);
        chk("mis_stall", {31'h0, m_stall}, 32'h0);
        cyc();
        m_req_valid = 1'b0; #1;
        chk("mis_no_valid", {31'h0, m_bus_valid}, 32'h0);
        chk("mis_err_gone", {31'h0, m_misalign_err}, 32'h0);
        m_req_valid = 1'b1; m_mem_read = 3'b011; m_addr = 32'h403; #1;
        chk("mis_lbu_err", {31'h0, m_misalign_err}, 32'h0);
        chk("mis_lbu_stall", {31'h0, m_stall}, 32'h1);
        m_req_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
